// File: rtl/commit_arbiter_if.sv
// Result bus between the execution branches, the commit arbiter and the writeback consumer.
// Upstream fields are flattened per branch (branch i in slice i); the output side carries one result.
`ifndef N_INSTR_BRANCHES
`define N_INSTR_BRANCHES 4
`endif

interface commit_arbiter_if #(
  parameter int data_width = 16,
  parameter int n_blocks   = 256,
  parameter int n_branches = `N_INSTR_BRANCHES
);
  localparam int BLK_W = (n_blocks > 1) ? $clog2(n_blocks) : 1;
  localparam int BR_W  = (n_branches > 1) ? $clog2(n_branches) : 1;

  logic [n_branches-1:0]            in_valid;
  logic [n_branches-1:0]            in_ready;
  logic [n_branches*BLK_W-1:0]      block_in;
  logic [n_branches*4-1:0]          dest_in;
  logic [n_branches*data_width-1:0] data_in;
  logic [n_branches*9-1:0]          commit_id_in;
  logic [n_branches-1:0]            commit_flag_in;

  logic                             out_valid;
  logic                             out_ready;
  logic [BLK_W-1:0]                 block_out;
  logic [3:0]                       dest_out;
  logic signed [data_width-1:0]     data_out;
  logic [8:0]                       commit_id_out;
  logic                             commit_flag_out;
  logic [BR_W-1:0]                  src_branch_out;

  modport master (
    output in_valid, block_in, dest_in, data_in, commit_id_in, commit_flag_in, out_ready,
    input  in_ready, out_valid, block_out, dest_out, data_out, commit_id_out,
           commit_flag_out, src_branch_out
  );

  modport slave (
    input  in_valid, block_in, dest_in, data_in, commit_id_in, commit_flag_in, out_ready,
    output in_ready, out_valid, block_out, dest_out, data_out, commit_id_out,
           commit_flag_out, src_branch_out
  );
endinterface

// File: rtl/commit_arbiter.sv
// Merges branch results into one commit stream: ordered items in commit_id order, others round-robin.
// 1-cycle accept-to-out_valid; in_ready drops while the output register is stalled. Watchdog: COMMIT_WATCHDOG_EN.
`ifndef N_INSTR_BRANCHES
`define N_INSTR_BRANCHES 4
`endif

module commit_arbiter #(
  parameter int data_width = 16,
  parameter int n_blocks   = 256,
  parameter int n_branches = `N_INSTR_BRANCHES,
  parameter int timeout    = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             sample_tick,
  commit_arbiter_if.slave  bus,
  output logic [8:0]       expected_id,
  output logic             stall_error
);
  localparam int BLK_W = (n_blocks > 1) ? $clog2(n_blocks) : 1;
  localparam int BR_W  = (n_branches > 1) ? $clog2(n_branches) : 1;

  if (timeout < 1) begin : g_timeout_chk
    $error("commit_arbiter: timeout must be at least 1");
  end

  logic [BLK_W-1:0]      w_blk  [n_branches];
  logic [3:0]            w_dst  [n_branches];
  logic [data_width-1:0] w_dat  [n_branches];
  logic [8:0]            w_cid  [n_branches];
  logic [n_branches-1:0] w_ord_req;
  logic [n_branches-1:0] w_rr_req;

  logic                  r_out_valid;
  logic [BLK_W-1:0]      r_block;
  logic [3:0]            r_dest;
  logic [data_width-1:0] r_data;
  logic [8:0]            r_cid;
  logic                  r_cflag;
  logic [BR_W-1:0]       r_src;
  logic [8:0]            r_expected_id;
  logic [BR_W-1:0]       r_rr_ptr;

  for (genvar i = 0; i < n_branches; i++) begin : g_unpack
    assign w_blk[i]     = bus.block_in[i*BLK_W +: BLK_W];
    assign w_dst[i]     = bus.dest_in[i*4 +: 4];
    assign w_dat[i]     = bus.data_in[i*data_width +: data_width];
    assign w_cid[i]     = bus.commit_id_in[i*9 +: 9];
    assign w_ord_req[i] = bus.in_valid[i] & bus.commit_flag_in[i] & (w_cid[i] == r_expected_id);
    assign w_rr_req[i]  = bus.in_valid[i] & ~bus.commit_flag_in[i];
  end

  logic            w_slot_free;
  logic            w_ord_hit;
  logic [BR_W-1:0] w_ord_idx;
  logic            w_rr_hit;
  logic [BR_W-1:0] w_rr_idx;
  logic            w_grant_vld;
  logic [BR_W-1:0] w_grant_idx;
  logic            w_accept;

  assign w_slot_free = ~r_out_valid | bus.out_ready;

  // Descending scans so the last hit written is the lowest index / nearest to rr_ptr.
  always_comb begin : ord_search
    w_ord_hit = 1'b0;
    w_ord_idx = '0;
    for (int i = n_branches - 1; i >= 0; i--) begin
      if (w_ord_req[i]) begin
        w_ord_hit = 1'b1;
        w_ord_idx = BR_W'(i);
      end
    end
  end

  always_comb begin : rr_search
    int              idx;
    logic [BR_W-1:0] j;
    w_rr_hit = 1'b0;
    w_rr_idx = '0;
    idx      = 0;
    j        = '0;
    for (int k = n_branches - 1; k >= 0; k--) begin
      idx = int'(r_rr_ptr) + k;
      if (idx >= n_branches) idx = idx - n_branches;
      j = BR_W'(idx);
      if (w_rr_req[j]) begin
        w_rr_hit = 1'b1;
        w_rr_idx = j;
      end
    end
  end

  assign w_grant_vld = enable & ~reset & w_slot_free & (w_ord_hit | w_rr_hit);
  assign w_grant_idx = w_ord_hit ? w_ord_idx : w_rr_idx;

  always_comb begin
    bus.in_ready = '0;
    if (w_grant_vld) bus.in_ready[w_grant_idx] = 1'b1;
  end

  assign w_accept = |(bus.in_valid & bus.in_ready);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid   <= 1'b0;
      r_block       <= '0;
      r_dest        <= '0;
      r_data        <= '0;
      r_cid         <= '0;
      r_cflag       <= 1'b0;
      r_src         <= '0;
      r_expected_id <= '0;
      r_rr_ptr      <= '0;
    end else if (enable) begin
      if (w_accept) begin
        r_out_valid <= 1'b1;
        r_block     <= w_blk[w_grant_idx];
        r_dest      <= w_dst[w_grant_idx];
        r_data      <= w_dat[w_grant_idx];
        r_cid       <= w_cid[w_grant_idx];
        r_cflag     <= w_ord_hit;
        r_src       <= w_grant_idx;
        if (!w_ord_hit)
          r_rr_ptr <= (w_grant_idx == BR_W'(n_branches - 1)) ? '0 : w_grant_idx + 1'b1;
      end else if (bus.out_ready && r_out_valid) begin
        r_out_valid <= 1'b0;
      end
      // A new sample program restarts the ordering chain even if an ordered item commits now.
      if (sample_tick)
        r_expected_id <= '0;
      else if (w_accept && w_ord_hit)
        r_expected_id <= r_expected_id + 9'd1;
    end
  end

  assign bus.out_valid       = r_out_valid;
  assign bus.block_out       = r_block;
  assign bus.dest_out        = r_dest;
  assign bus.data_out        = $signed(r_data);
  assign bus.commit_id_out   = r_cid;
  assign bus.commit_flag_out = r_cflag;
  assign bus.src_branch_out  = r_src;
  assign expected_id         = r_expected_id;

`ifdef COMMIT_WATCHDOG_EN
  logic [15:0] r_wd_cnt;
  logic        r_stall_error;
  logic        w_ord_pending;

  assign w_ord_pending = |(bus.in_valid & bus.commit_flag_in);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wd_cnt      <= '0;
      r_stall_error <= 1'b0;
    end else if (enable) begin
      if (sample_tick) begin
        r_wd_cnt      <= '0;
        r_stall_error <= 1'b0;
      end else if (w_accept) begin
        r_wd_cnt <= '0;
      end else if (w_ord_pending && (r_wd_cnt != 16'(timeout))) begin
        r_wd_cnt <= r_wd_cnt + 16'd1;
        if (r_wd_cnt + 16'd1 == 16'(timeout)) r_stall_error <= 1'b1;
      end
    end
  end

  assign stall_error = r_stall_error;
`else
  assign stall_error = 1'b0;
`endif

endmodule

// File: tb/tb_commit_arbiter.sv
// Directed bench for commit_arbiter: ordering, round-robin, back-pressure, wrap/tick, reset, watchdog.
`ifndef N_INSTR_BRANCHES
`define N_INSTR_BRANCHES 4
`endif

module tb_commit_arbiter;
  localparam int NB   = 4;
  localparam int DW   = 16;
  localparam int NBLK = 256;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       sample_tick;
  logic [8:0] expected_id;
  logic       stall_error;

  logic [NB-1:0]    t_vld;
  logic [NB-1:0]    t_flg;
  logic [NB*9-1:0]  t_id;
  logic [NB*DW-1:0] t_dat;
  logic [NB*4-1:0]  t_dst;
  logic [NB*8-1:0]  t_blk;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  commit_arbiter_if #(.data_width(DW), .n_blocks(NBLK), .n_branches(NB)) u_if ();

  assign u_if.in_valid       = t_vld;
  assign u_if.commit_flag_in = t_flg;
  assign u_if.commit_id_in   = t_id;
  assign u_if.data_in        = t_dat;
  assign u_if.dest_in        = t_dst;
  assign u_if.block_in       = t_blk;

  commit_arbiter #(.data_width(DW), .n_blocks(NBLK), .n_branches(NB), .timeout(8)) u_dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .sample_tick (sample_tick),
    .bus         (u_if.slave),
    .expected_id (expected_id),
    .stall_error (stall_error)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_item(input int br, input logic flg, input logic [8:0] id,
                          input logic [15:0] dat, input logic [3:0] dst, input logic [7:0] blk);
    t_vld[br]         = 1'b1;
    t_flg[br]         = flg;
    t_id[br*9 +: 9]   = id;
    t_dat[br*DW +: DW] = dat;
    t_dst[br*4 +: 4]  = dst;
    t_blk[br*8 +: 8]  = blk;
  endtask

  task automatic clr(input int br);
    t_vld[br] = 1'b0;
  endtask

  task automatic do_reset();
    t_vld = '0; t_flg = '0; t_id = '0; t_dat = '0; t_dst = '0; t_blk = '0;
    sample_tick = 1'b0;
    enable      = 1'b1;
    u_if.out_ready = 1'b1;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    do_reset();
    // Reset state, with a valid request held during reset to show in_ready stays low.
    set_item(0, 1'b0, 9'd0, 16'h0DEF, 4'd0, 8'd0);
    reset = 1'b1;
    #1;
    chk("rst_in_ready", 32'(u_if.in_ready), 32'h0);
    step();
    chk("rst_out_valid", 32'(u_if.out_valid), 32'h0);
    chk("rst_expected_id", 32'(expected_id), 32'h0);
    chk("rst_stall_error", 32'(stall_error), 32'h0);
    chk("rst_data_out", 32'($unsigned(u_if.data_out)), 32'h0);
    clr(0);
    reset = 1'b0;
    step();

    // Out-of-order arrival: id 1 waits until id 0 shows up three cycles later.
    set_item(1, 1'b1, 9'd1, 16'h1111, 4'd1, 8'd1);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("ooo_wait_ready", 32'(u_if.in_ready), 32'h0);
      step();
      chk("ooo_wait_valid", 32'(u_if.out_valid), 32'h0);
    end
    set_item(0, 1'b1, 9'd0, 16'h2222, 4'd2, 8'd2);
    #1;
    chk("ooo_grant0", 32'(u_if.in_ready), 32'h1);
    step();
    clr(0);
    chk("ooo_cid0", 32'(u_if.commit_id_out), 32'd0);
    chk("ooo_src0", 32'(u_if.src_branch_out), 32'd0);
    chk("ooo_data0", 32'($unsigned(u_if.data_out)), 32'h2222);
    chk("ooo_exp1", 32'(expected_id), 32'd1);
    #1;
    chk("ooo_grant1", 32'(u_if.in_ready), 32'h2);
    step();
    clr(1);
    chk("ooo_cid1", 32'(u_if.commit_id_out), 32'd1);
    chk("ooo_src1", 32'(u_if.src_branch_out), 32'd1);
    chk("ooo_flag1", 32'(u_if.commit_flag_out), 32'd1);
    chk("ooo_exp2", 32'(expected_id), 32'd2);
    step();
    chk("ooo_drain", 32'(u_if.out_valid), 32'h0);

    // Round-robin over four continuously valid unordered branches.
    for (int b = 0; b < NB; b++) set_item(b, 1'b0, 9'd0, 16'(16'h0100 + b), 4'(b), 8'(b));
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("rr_ready", 32'(u_if.in_ready), 32'(1 << (k % 4)));
      step();
      chk("rr_src", 32'(u_if.src_branch_out), 32'(k % 4));
    end
    chk("rr_exp_kept", 32'(expected_id), 32'd2);
    t_vld = '0;

    // Ordered priority: bring expected_id to 5 via branch 3, then mix in unordered branches.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      set_item(3, 1'b1, 9'(k), 16'h3000, 4'd3, 8'd3);
      step();
    end
    chk("pri_exp5", 32'(expected_id), 32'd5);
    set_item(3, 1'b1, 9'd5, 16'h3005, 4'd3, 8'd3);
    set_item(0, 1'b0, 9'd0, 16'h0A00, 4'd0, 8'd0);
    set_item(2, 1'b0, 9'd0, 16'h0A02, 4'd2, 8'd2);
    #1;
    chk("pri_first", 32'(u_if.in_ready), 32'h8);
    step();
    clr(3);
    chk("pri_src3", 32'(u_if.src_branch_out), 32'd3);
    chk("pri_cid5", 32'(u_if.commit_id_out), 32'd5);
    #1;
    chk("pri_second", 32'(u_if.in_ready), 32'h1);
    step();
    clr(0);
    chk("pri_src0", 32'(u_if.src_branch_out), 32'd0);
    #1;
    chk("pri_third", 32'(u_if.in_ready), 32'h4);
    step();
    clr(2);
    chk("pri_src2", 32'(u_if.src_branch_out), 32'd2);
    chk("pri_exp6", 32'(expected_id), 32'd6);

    // Back-pressure: three stalled cycles, held output, then the waiting item passes.
    do_reset();
    set_item(1, 1'b0, 9'd0, 16'hAAAA, 4'd3, 8'd9);
    #1;
    chk("bp_first", 32'(u_if.in_ready), 32'h2);
    step();
    clr(1);
    u_if.out_ready = 1'b0;
    set_item(2, 1'b0, 9'd0, 16'hBBBB, 4'd4, 8'd10);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("bp_ready_low", 32'(u_if.in_ready), 32'h0);
      step();
      chk("bp_hold_data", 32'($unsigned(u_if.data_out)), 32'hAAAA);
      chk("bp_hold_valid", 32'(u_if.out_valid), 32'h1);
    end
    u_if.out_ready = 1'b1;
    #1;
    chk("bp_resume", 32'(u_if.in_ready), 32'h4);
    step();
    clr(2);
    chk("bp_data_b", 32'($unsigned(u_if.data_out)), 32'hBBBB);
    chk("bp_dest_b", 32'(u_if.dest_out), 32'd4);
    chk("bp_blk_b", 32'(u_if.block_out), 32'd10);
    step();
    chk("bp_drain", 32'(u_if.out_valid), 32'h0);

    // Enable low freezes everything and blocks grants.
    enable = 1'b0;
    set_item(0, 1'b0, 9'd0, 16'h0E0E, 4'd0, 8'd0);
    #1;
    chk("en_low_ready", 32'(u_if.in_ready), 32'h0);
    step();
    chk("en_low_valid", 32'(u_if.out_valid), 32'h0);
    clr(0);
    enable = 1'b1;

    // Wrap 511 -> 0, then sample_tick racing an ordered accept of id 7.
    do_reset();
    for (int k = 0; k < 511; k++) begin
      set_item(0, 1'b1, 9'(k), 16'h0001, 4'd0, 8'd0);
      step();
    end
    chk("wrap_exp511", 32'(expected_id), 32'd511);
    set_item(0, 1'b1, 9'd511, 16'h01FF, 4'd0, 8'd0);
    step();
    chk("wrap_exp0", 32'(expected_id), 32'd0);
    chk("wrap_cid511", 32'(u_if.commit_id_out), 32'd511);
    for (int k = 0; k < 7; k++) begin
      set_item(0, 1'b1, 9'(k), 16'h0002, 4'd0, 8'd0);
      step();
    end
    chk("tick_exp7", 32'(expected_id), 32'd7);
    set_item(0, 1'b1, 9'd7, 16'h0007, 4'd0, 8'd0);
    sample_tick = 1'b1;
    #1;
    chk("tick_grant", 32'(u_if.in_ready), 32'h1);
    step();
    sample_tick = 1'b0;
    clr(0);
    chk("tick_exp0", 32'(expected_id), 32'd0);
    chk("tick_cid7", 32'(u_if.commit_id_out), 32'd7);

    // Reset while a result is held downstream drops it.
    set_item(1, 1'b0, 9'd0, 16'h5A5A, 4'd5, 8'd5);
    u_if.out_ready = 1'b0;
    step();
    clr(1);
    chk("rmid_valid_pre", 32'(u_if.out_valid), 32'h1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rmid_valid", 32'(u_if.out_valid), 32'h0);
    chk("rmid_data", 32'($unsigned(u_if.data_out)), 32'h0);

    // Stalled ordering chain: branch 0 holds id 3 while id 0 is expected.
    do_reset();
    set_item(0, 1'b1, 9'd3, 16'h0303, 4'd0, 8'd0);
`ifdef COMMIT_WATCHDOG_EN
    for (int c = 0; c < 7; c++) step();
    chk("wd_before", 32'(stall_error), 32'h0);
    chk("wd_no_grant", 32'(u_if.in_ready), 32'h0);
    step();
    chk("wd_set", 32'(stall_error), 32'h1);
    step();
    chk("wd_sticky", 32'(stall_error), 32'h1);
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    chk("wd_tick_clear", 32'(stall_error), 32'h0);
`else
    for (int c = 0; c < 10; c++) step();
    chk("wd_off", 32'(stall_error), 32'h0);
    chk("wd_no_grant", 32'(u_if.in_ready), 32'h0);
`endif
    clr(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule

// File: doc/commit_arbiter.md
# commit_arbiter

Merges result streams from the instruction execution branches back into one commit/writeback stream. It sits downstream of the per-branch execution units, mirroring the branch dispatch stage that fans instructions out. Results flagged for ordered commit are released strictly in `commit_id` order. Unordered results fill the remaining slots round-robin. An optional watchdog flags a stalled ordering chain.

## Interface

Parameters:
- `data_width`, 16: result data width.
- `n_blocks`, 256: block count; block field is `$clog2(n_blocks)` bits.
- `n_branches`, `` `N_INSTR_BRANCHES ``: number of upstream branches.
- `timeout`, 1024: watchdog limit in cycles; used only when `COMMIT_WATCHDOG_EN` is defined.

Ports (name, direction, width, meaning):
- `clk`, in, 1: single clock.
- `reset`, in, 1: synchronous, active-high.
- `enable`, in, 1: when low, all state holds and `in_ready` is 0.
- `sample_tick`, in, 1: start of a new sample program.
- `in_valid`, in, n_branches: per-branch result valid.
- `in_ready`, out, n_branches: per-branch accept; one-hot or zero.
- `block_in`, in, n_branches*$clog2(n_blocks): flattened per-branch block index; branch i occupies slice i.
- `dest_in`, in, n_branches*4: flattened destination register.
- `data_in`, in, n_branches*data_width: flattened signed result.
- `commit_id_in`, in, n_branches*9: flattened commit id.
- `commit_flag_in`, in, n_branches: 1 means ordered result.
- `out_valid`, out, 1: output register holds a result.
- `out_ready`, in, 1: downstream accept.
- `block_out`, `dest_out`, `data_out`, `commit_id_out`, `commit_flag_out`, out, matching widths: registered result fields.
- `src_branch_out`, out, $clog2(n_branches): index of the branch that produced the result.
- `expected_id`, out, 9: next ordered commit id.
- `stall_error`, out, 1: sticky watchdog flag.

## Operation

- Output stage is one register. `slot_free = ~out_valid | out_ready`.
- Each cycle with `enable & slot_free`, select at most one branch:
  - Ordered match: `in_valid[i] & commit_flag_in[i] & commit_id_in[i] == expected_id`. If several branches match, the lowest index wins.
  - Otherwise, round-robin over `in_valid[i] & ~commit_flag_in[i]`. Search starts at `rr_ptr`. On a grant, `rr_ptr` becomes the granted index + 1, modulo n_branches.
  - Ordered items whose id does not match are never granted.
- `in_ready[g]` is driven combinationally high for the granted branch only.
- Accept means `in_valid[g] & in_ready[g]`. On accept:
  - All fields of branch g load into the output register.
  - `out_valid` is set to 1.
  - If the item is ordered, `expected_id` increments, wrapping 511 -> 0.
- If `out_ready & out_valid` with no accept in the same cycle, `out_valid` clears to 0.
- `sample_tick`: `expected_id` becomes 0. If an ordered accept happens in the same cycle, the tick wins and `expected_id` is 0. The output register and `rr_ptr` are not affected.
- Reset values: `out_valid`=0, `in_ready`=0, `expected_id`=0, `rr_ptr`=0, `stall_error`=0. Data fields reset to 0.
- Reset mid-transfer drops the held result.

## Timing

- Latency from an input accept to `out_valid` is 1 cycle.
- Throughput is 1 result per cycle while `out_ready` stays high.
- A downstream stall (`out_ready`=0 while `out_valid`=1) forces `in_ready`=0 the same cycle.
- Arbitration is combinational from `in_valid`, `commit_*`, `expected_id`, and `rr_ptr`. There is no ready→valid combinational path.
- Upstream must hold a payload stable while `in_valid & ~in_ready`.

## Configuration

- `COMMIT_WATCHDOG_EN` defined:
  - A 16-bit counter increments on every enabled cycle where at least one branch has a valid ordered item and no accept occurs.
  - The counter clears on any accept, on `sample_tick`, and on reset.
  - When the counter reaches `timeout`, `stall_error` sets.
  - `stall_error` is sticky until reset or `sample_tick`.
- `COMMIT_WATCHDOG_EN` undefined: `stall_error` is constant 0 and no counter exists.

## Test plan

- Out-of-order arrival:
  - Stimulus: branch 1 presents ordered id 1 in cycle 0; branch 0 presents ordered id 0 in cycle 3.
  - Response: no grant in cycles 0–2. Branch 0 is accepted in cycle 3 and branch 1 in cycle 4. `commit_id_out` sequence is 0, 1. `expected_id` ends at 2.
- Round-robin fairness:
  - Stimulus: all 4 branches hold unordered items continuously; `out_ready`=1.
  - Response: grant order is 0, 1, 2, 3, 0, …
- Ordered priority:
  - Stimulus: `expected_id`=5; branch 3 holds ordered id 5; branches 0 and 2 hold unordered items.
  - Response: branch 3 is granted first, then branch 0.
- Back-pressure:
  - Stimulus: `out_ready`=0 for 3 cycles while `out_valid`=1.
  - Response: `in_ready`=0 throughout; the output fields stay unchanged; no loss when `out_ready` returns to 1.
- Wrap and tick:
  - Stimulus 1: `expected_id`=511 and id 511 is accepted. Response: `expected_id`=0.
  - Stimulus 2: `sample_tick` coincides with an ordered accept of id 7. Response: `expected_id`=0.
- Watchdog (`COMMIT_WATCHDOG_EN`, `timeout`=8):
  - Stimulus: branch 0 holds ordered id 3 while `expected_id`=0.
  - Response: `stall_error` rises after 8 stalled cycles. `sample_tick` clears it.
